// File: rtl/ram2_arbiter.sv
// ram2_arbiter
//   Shares the single RAM2 SRAM between instruction fetch and MEM-stage
//   data loads/stores. Instruction fetch owns the memory by default. A data
//   request steals it for a few cycles. While that happens the PC is frozen
//   and a NOP bubble goes to decode.
//
// Ports
//   rai_clk, rai_rst        clock, asynchronous active-high reset
//   rai_if_addr             PC address to fetch
//   rai_mem_req/we/addr/wdata  data access request (held until rao_mem_ack)
//   rai_ram2_rdata          data bus as read back from the RAM2 pads
//   rao_ram2_addr/wdata     RAM2 address and write data
//   rao_ram2_drive          tristate enable for rao_ram2_wdata
//   rao_ram2_en_n/oe_n/we_n RAM2 control strobes, active low
//   rao_pc_en               enable to the pc block (0 = stall)
//   rao_instr               fetched instruction or NOP bubble
//   rao_mem_rdata           load data
//   rao_mem_ack             one-cycle completion pulse
module ram2_arbiter #(
    parameter int unsigned     WE_CYCLES = 2,
    parameter logic [15:0]     NOP_INSTR = 16'h0800
) (
    input  logic        rai_clk,
    input  logic        rai_rst,
    input  logic [15:0] rai_if_addr,
    input  logic        rai_mem_req,
    input  logic        rai_mem_we,
    input  logic [15:0] rai_mem_addr,
    input  logic [15:0] rai_mem_wdata,
    input  logic [15:0] rai_ram2_rdata,
    output logic [15:0] rao_ram2_addr,
    output logic [15:0] rao_ram2_wdata,
    output logic        rao_ram2_drive,
    output logic        rao_ram2_en_n,
    output logic        rao_ram2_oe_n,
    output logic        rao_ram2_we_n,
    output logic        rao_pc_en,
    output logic [15:0] rao_instr,
    output logic [15:0] rao_mem_rdata,
    output logic        rao_mem_ack
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DREAD  = 3'd1,
        WSETUP = 3'd2,
        WPULSE = 3'd3,
        WHOLD  = 3'd4
    } state_t;

    // Pulse counter reload: we_n stays low for WE_CYCLES cycles, counting
    // down from WE_CYCLES-1 to 0 inclusive.
    localparam logic [3:0] CNT_LOAD = 4'(WE_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic [15:0] rdata_r;

    // Access sequencer: state, we_n pulse counter, latched request, load data.
    always_ff @(posedge rai_clk or posedge rai_rst) begin
        if (rai_rst) begin
            state_r <= FETCH;
            cnt_r   <= 4'd0;
            addr_r  <= 16'd0;
            wdata_r <= 16'd0;
            rdata_r <= 16'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    // The request is only looked at here, so every access
                    // is separated from the next by at least one FETCH cycle.
                    if (rai_mem_req) begin
                        addr_r  <= rai_mem_addr;
                        wdata_r <= rai_mem_wdata;
                        state_r <= rai_mem_we ? WSETUP : DREAD;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DREAD: begin
                    rdata_r <= rai_ram2_rdata;
                    state_r <= FETCH;
                end
                WSETUP: begin
                    cnt_r   <= CNT_LOAD;
                    state_r <= WPULSE;
                end
                WPULSE: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= WHOLD;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                        state_r <= WPULSE;
                    end
                end
                WHOLD: begin
                    state_r <= FETCH;
                end
                default: begin
                    state_r <= FETCH;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Output decode. Reset overrides everything combinationally, so a write
    // in progress loses we_n and the bus drive in the same cycle.
    always_comb begin
        rao_ram2_addr  = 16'd0;
        rao_ram2_wdata = wdata_r;
        rao_ram2_drive = 1'b0;
        rao_ram2_en_n  = 1'b1;
        rao_ram2_oe_n  = 1'b1;
        rao_ram2_we_n  = 1'b1;
        rao_pc_en      = 1'b0;
        rao_instr      = NOP_INSTR;
        rao_mem_rdata  = rdata_r;
        rao_mem_ack    = 1'b0;
        if (rai_rst) begin
            rao_ram2_addr = 16'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    rao_ram2_addr = rai_if_addr;
                    rao_ram2_en_n = 1'b0;
                    rao_ram2_oe_n = 1'b0;
                    if (rai_mem_req) begin
                        rao_pc_en = 1'b0;
                        rao_instr = NOP_INSTR;
                    end else begin
                        rao_pc_en = 1'b1;
                        rao_instr = rai_ram2_rdata;
                    end
                end
                DREAD: begin
                    rao_ram2_addr = addr_r;
                    rao_ram2_en_n = 1'b0;
                    rao_ram2_oe_n = 1'b0;
                    rao_mem_rdata = rai_ram2_rdata;
                    rao_mem_ack   = 1'b1;
                end
                WSETUP, WPULSE, WHOLD: begin
                    rao_ram2_addr  = addr_r;
                    rao_ram2_en_n  = 1'b0;
                    rao_ram2_drive = 1'b1;
                    rao_ram2_we_n  = (state_r == WPULSE) ? 1'b0 : 1'b1;
                    rao_mem_ack    = (state_r == WHOLD) ? 1'b1 : 1'b0;
                end
                default: begin
                    rao_ram2_addr = 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram2_arbiter.sv
module tb_ram2_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_addr = 16'd0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = 16'd0;
    logic [15:0] mem_wdata = 16'd0;
    logic [15:0] ram2_rdata = 16'd0;
    logic [15:0] ram2_addr;
    logic [15:0] ram2_wdata;
    logic        ram2_drive;
    logic        ram2_en_n;
    logic        ram2_oe_n;
    logic        ram2_we_n;
    logic        pc_en;
    logic [15:0] instr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    // {en_n, oe_n, we_n, drive, pc_en, ack}
    logic [5:0] ctrl;
    assign ctrl = {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_drive, pc_en, mem_ack};

    localparam logic [5:0] C_RST   = 6'b111000;
    localparam logic [5:0] C_FETCH = 6'b001010;
    localparam logic [5:0] C_STALL = 6'b001000;
    localparam logic [5:0] C_DREAD = 6'b001001;
    localparam logic [5:0] C_WSET  = 6'b011100;
    localparam logic [5:0] C_WPUL  = 6'b010100;
    localparam logic [5:0] C_WHOLD = 6'b011101;

    ram2_arbiter #(.WE_CYCLES(2), .NOP_INSTR(16'h0800)) dut (
        .rai_clk        (clk),
        .rai_rst        (rst),
        .rai_if_addr    (if_addr),
        .rai_mem_req    (mem_req),
        .rai_mem_we     (mem_we),
        .rai_mem_addr   (mem_addr),
        .rai_mem_wdata  (mem_wdata),
        .rai_ram2_rdata (ram2_rdata),
        .rao_ram2_addr  (ram2_addr),
        .rao_ram2_wdata (ram2_wdata),
        .rao_ram2_drive (ram2_drive),
        .rao_ram2_en_n  (ram2_en_n),
        .rao_ram2_oe_n  (ram2_oe_n),
        .rao_ram2_we_n  (ram2_we_n),
        .rao_pc_en      (pc_en),
        .rao_instr      (instr),
        .rao_mem_rdata  (mem_rdata),
        .rao_mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled 1 time unit later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        #1;
        n_cmp++; if (ctrl !== C_RST) begin n_bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RST); end
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL reset_instr: got %h want 0800", instr); end
        n_cmp++; if (ram2_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", ram2_addr); end
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", mem_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [15:0] data [3] = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            tick();
            if_addr    = 16'(i);
            ram2_rdata = data[i];
            #1;
            n_cmp++; if (ctrl !== C_FETCH) begin n_bad++; $display("FAIL fetch_ctrl[%0d]: got %b want %b", i, ctrl, C_FETCH); end
            n_cmp++; if (instr !== data[i]) begin n_bad++; $display("FAIL fetch_instr[%0d]: got %h want %h", i, instr, data[i]); end
            n_cmp++; if (ram2_addr !== 16'(i)) begin n_bad++; $display("FAIL fetch_addr[%0d]: got %h want %h", i, ram2_addr, 16'(i)); end
        end
    endtask

    task automatic test_read();
        tick();
        if_addr = 16'h0003; ram2_rdata = 16'h5555;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h4000;
        #1;
        n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL rd_fetch_ctrl: got %b want %b", ctrl, C_STALL); end
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL rd_fetch_instr: got %h want 0800", instr); end
        tick();
        ram2_rdata = 16'hBEEF; if_addr = 16'h0004;
        #1;
        n_cmp++; if (ctrl !== C_DREAD) begin n_bad++; $display("FAIL rd_dread_ctrl: got %b want %b", ctrl, C_DREAD); end
        n_cmp++; if (ram2_addr !== 16'h4000) begin n_bad++; $display("FAIL rd_addr: got %h want 4000", ram2_addr); end
        n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL rd_dread_instr: got %h want 0800", instr); end
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h want beef", mem_rdata); end
        tick();
        mem_req = 1'b0; ram2_rdata = 16'h9999;
        #1;
        n_cmp++; if (ctrl !== C_FETCH) begin n_bad++; $display("FAIL rd_after_ctrl: got %b want %b", ctrl, C_FETCH); end
        n_cmp++; if (mem_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL rd_held: got %h want beef", mem_rdata); end
        n_cmp++; if (instr !== 16'h9999) begin n_bad++; $display("FAIL rd_after_instr: got %h want 9999", instr); end
    endtask

    // Write with request fields changed mid-access; RAM2 must keep the latched
    // address/data. When b2b is set a read to 0x4002 is requested right after ack.
    task automatic run_write(input bit b2b);
        logic [5:0] exp_c [4] = '{C_WSET, C_WPUL, C_WPUL, C_WHOLD};
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h4001; mem_wdata = 16'h1234;
        #1;
        n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL wr_fetch_ctrl: got %b want %b", ctrl, C_STALL); end
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_addr = 16'h7777; mem_wdata = 16'h7777; if_addr = 16'h0100 + 16'(i);
            #1;
            n_cmp++; if (ctrl !== exp_c[i]) begin n_bad++; $display("FAIL wr_ctrl[%0d]: got %b want %b", i, ctrl, exp_c[i]); end
            n_cmp++; if (ram2_addr !== 16'h4001 || ram2_wdata !== 16'h1234) begin n_bad++; $display("FAIL wr_bus[%0d]: got %h/%h want 4001/1234", i, ram2_addr, ram2_wdata); end
            n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL wr_instr[%0d]: got %h want 0800", i, instr); end
        end
        tick();
        if (b2b) begin
            mem_we = 1'b0; mem_addr = 16'h4002; ram2_rdata = 16'hAAAA;
            #1;
            n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL b2b_gap_ctrl: got %b want %b", ctrl, C_STALL); end
            n_cmp++; if (instr !== 16'h0800) begin n_bad++; $display("FAIL b2b_gap_instr: got %h want 0800", instr); end
            tick();
            ram2_rdata = 16'hCAFE;
            #1;
            n_cmp++; if (ctrl !== C_DREAD) begin n_bad++; $display("FAIL b2b_dread_ctrl: got %b want %b", ctrl, C_DREAD); end
            n_cmp++; if (ram2_addr !== 16'h4002) begin n_bad++; $display("FAIL b2b_addr: got %h want 4002", ram2_addr); end
            n_cmp++; if (mem_rdata !== 16'hCAFE) begin n_bad++; $display("FAIL b2b_data: got %h want cafe", mem_rdata); end
            tick();
        end
        mem_req = 1'b0; ram2_rdata = 16'h4444;
        #1;
        n_cmp++; if (ctrl !== C_FETCH) begin n_bad++; $display("FAIL wr_end_ctrl: got %b want %b", ctrl, C_FETCH); end
        n_cmp++; if (instr !== 16'h4444) begin n_bad++; $display("FAIL wr_end_instr: got %h want 4444", instr); end
    endtask

    task automatic test_write();
        run_write(1'b0);
    endtask

    task automatic test_back_to_back();
        run_write(1'b1);
    endtask

    task automatic test_reset_mid_write();
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h4005; mem_wdata = 16'h5A5A;
        tick();
        tick();
        #1;
        n_cmp++; if (ctrl !== C_WPUL) begin n_bad++; $display("FAIL rstw_pulse_ctrl: got %b want %b", ctrl, C_WPUL); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ctrl !== C_RST) begin n_bad++; $display("FAIL rstw_abort_ctrl: got %b want %b", ctrl, C_RST); end
        mem_req = 1'b0;
        tick();
        n_cmp++; if (ctrl !== C_RST) begin n_bad++; $display("FAIL rstw_held_ctrl: got %b want %b", ctrl, C_RST); end
        rst = 1'b0; ram2_rdata = 16'h1357; if_addr = 16'h0010;
        #1;
        n_cmp++; if (ctrl !== C_FETCH) begin n_bad++; $display("FAIL rstw_release_ctrl: got %b want %b", ctrl, C_FETCH); end
        n_cmp++; if (mem_rdata !== 16'h0000) begin n_bad++; $display("FAIL rstw_rdata: got %h want 0000", mem_rdata); end
        tick();
        n_cmp++; if (ctrl !== C_FETCH || ram2_addr !== 16'h0010) begin n_bad++; $display("FAIL rstw_next: got %b/%h want %b/0010", ctrl, ram2_addr, C_FETCH); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
